// File: rtl/hp_rd_arbiter.sv
// hp_rd_arbiter
// -----------------------------------------------------------------------------
// Round-robin read arbiter. It shares one AXI HP slave port between REQ_NUM
// requesters. Only the read address (AR) and read data (R) channels are
// handled. Each accepted burst carries its requester index in ARID. Returning
// R beats are steered back to the requester named by RID. A counter limits the
// number of bursts in flight to MAX_OUTSTANDING.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// when valid and ready are both high. Once m_axi_arvalid is raised, it stays
// high with a stable payload until m_axi_arready. req_arready is a one-cycle
// accept pulse: the requester sees its request taken in the cycle the pulse is
// high, and the payload is captured on that edge. R beats are passed through
// combinationally, so req_rvalid/req_rready follow the same rule in the same
// cycle as m_axi_rvalid/m_axi_rready.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_araddr/arlen/arvalid      per-requester burst requests (slice i)
//   req_arready                   one-hot accept pulse
//   req_rdata/rresp/rlast         read data, broadcast to all requesters
//   req_rvalid / req_rready       per-requester read data handshake
//   m_axi_ar*                     AR channel toward the HP port
//   m_axi_r*                      R channel from the HP port
//   outstanding                   bursts currently in flight
//   rid_err                       sticky: a beat arrived with RID >= REQ_NUM
// -----------------------------------------------------------------------------
module hp_rd_arbiter #(
    parameter int REQ_NUM         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 6,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_araddr,
    input  logic [REQ_NUM*8-1:0]          req_arlen,
    input  logic [REQ_NUM-1:0]            req_arvalid,
    output logic [REQ_NUM-1:0]            req_arready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                    req_rresp,
    output logic                          req_rlast,
    output logic [REQ_NUM-1:0]            req_rvalid,
    input  logic [REQ_NUM-1:0]            req_rready,
    output logic [ID_WIDTH-1:0]           m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [ID_WIDTH-1:0]           m_axi_rid,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [3:0]                    outstanding,
    output logic                          rid_err
);

    localparam int GW = $clog2(REQ_NUM);
    // One extra bit so that REQ_NUM == 2**ID_WIDTH still compares correctly.
    localparam logic [ID_WIDTH:0] REQ_NUM_ID = (ID_WIDTH + 1)'(REQ_NUM);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ar_state_t;

    ar_state_t       state;
    ar_state_t       state_next;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   cur_grant;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic            grant_found;
    logic            grant_ok;
    logic            ar_hs;
    logic            rid_bad;
    logic [GW-1:0]   rid_idx;
    logic            r_done;

    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state == ISSUE);

    // Round-robin search: the first valid requester after last_grant, with
    // wrap-around. The requester just served therefore has the lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = GW'((int'(last_grant) + k) % REQ_NUM);
            if (!grant_found && req_arvalid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // AR FSM: next state and outputs. The limit uses the registered count, so a
    // burst that completes in the grant cycle only frees a slot one cycle later.
    always_comb begin
        state_next  = state;
        req_arready = '0;
        grant_ok    = 1'b0;
        ar_hs       = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && grant_found &&
                    (outstanding < 4'(MAX_OUTSTANDING))) begin
                    grant_ok               = 1'b1;
                    req_arready[grant_idx] = 1'b1;
                    state_next             = ISSUE;
                end
            end
            ISSUE: begin
                if (m_axi_arready) begin
                    ar_hs      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // R steering is purely combinational. Beats with an unknown RID are
    // consumed here (rready forced high) so the HP port cannot stall on them.
    assign rid_bad      = ({1'b0, m_axi_rid} >= REQ_NUM_ID);
    assign rid_idx      = m_axi_rid[GW-1:0];
    assign m_axi_rready = rid_bad ? 1'b1 : req_rready[rid_idx];
    assign req_rdata    = m_axi_rdata;
    assign req_rresp    = m_axi_rresp;
    assign req_rlast    = m_axi_rlast;
    assign r_done       = m_axi_rvalid & m_axi_rready & m_axi_rlast;

    always_comb begin
        req_rvalid = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            req_rvalid[i] = m_axi_rvalid && (m_axi_rid == ID_WIDTH'(i));
        end
    end

    // AR payload, grant history, outstanding count and the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= GW'(REQ_NUM - 1);
            cur_grant    <= '0;
            m_axi_arid   <= '0;
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            outstanding  <= '0;
            rid_err      <= 1'b0;
        end else begin
            if (grant_ok) begin
                cur_grant    <= grant_idx;
                m_axi_arid   <= ID_WIDTH'(grant_idx);
                m_axi_araddr <= req_araddr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                m_axi_arlen  <= req_arlen[int'(grant_idx)*8 +: 8];
            end
            if (ar_hs) begin
                last_grant <= cur_grant;
            end
            // A decrement at zero saturates. This absorbs stale beats that
            // return after a reset.
            if (ar_hs && !r_done) begin
                outstanding <= outstanding + 4'd1;
            end else if (!ar_hs && r_done && (outstanding != 4'd0)) begin
                outstanding <= outstanding - 4'd1;
            end
            if (m_axi_rvalid && rid_bad) begin
                rid_err <= 1'b1;
            end
        end
    end

endmodule
